// File: rtl/tdm_demux.sv
// Word-interleaved TDM receiver: locks on start-of-frame, gathers N_CH words per frame
// and presents each complete frame atomically. Optional macro TDM_DEMUX_ERR_CNT_EN adds err_cnt.
module tdm_demux #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [W-1:0]      in_data,
   output logic              out_valid,
   output logic [N_CH*W-1:0] out_data,
   output logic              out_err,
`ifdef TDM_DEMUX_ERR_CNT_EN
   output logic [7:0]        err_cnt,
`endif
   output logic              locked
);

   localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

   typedef enum logic {HUNT, COLLECT} state_t;

   // Handshake: a word is consumed on every edge where in_valid=1; there is no
   // backpressure, and out_valid/out_err are single-cycle pulses with no acknowledge.

   state_t          state, state_nxt;
   logic [SW-1:0]   slot, slot_nxt;
   logic [W-1:0]    coll_buf [N_CH];
   logic            wr_en;
   logic [SW-1:0]   wr_slot;
   logic            frame_done;
   logic            err_nxt;
   logic [N_CH*W-1:0] frame_nxt;

   assign locked = (state == COLLECT);

   always_comb begin
      state_nxt  = state;
      slot_nxt   = slot;
      wr_en      = 1'b0;
      wr_slot    = slot;
      frame_done = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         HUNT: begin
            if (in_valid && in_sof) begin
               wr_en     = 1'b1;
               wr_slot   = '0;
               slot_nxt  = SW'(1);
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) begin
               if (in_sof) begin
                  // An sof mid-frame abandons the partial frame but resyncs in place.
                  err_nxt  = (slot != '0);
                  wr_en    = 1'b1;
                  wr_slot  = '0;
                  slot_nxt = SW'(1);
               end else if (slot == '0) begin
                  err_nxt   = 1'b1;
                  state_nxt = HUNT;
               end else begin
                  wr_en = 1'b1;
                  if (slot == LAST_SLOT) begin
                     frame_done = 1'b1;
                     slot_nxt   = '0;
                  end else begin
                     slot_nxt = slot + SW'(1);
                  end
               end
            end
         end
         default: begin
            state_nxt = HUNT;
            slot_nxt  = '0;
         end
      endcase
   end

   // The last word bypasses the buffer so the frame is published on the edge that accepts it.
   always_comb begin
      frame_nxt = '0;
      for (int k = 0; k < N_CH; k++) begin
         frame_nxt[k*W +: W] = (k == N_CH - 1) ? in_data : coll_buf[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         slot      <= '0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         out_data  <= '0;
         for (int k = 0; k < N_CH; k++) coll_buf[k] <= '0;
      end else begin
         state     <= state_nxt;
         slot      <= slot_nxt;
         out_valid <= frame_done;
         out_err   <= err_nxt;
         if (wr_en) coll_buf[wr_slot] <= in_data;
         if (frame_done) out_data <= frame_nxt;
      end
   end

`ifdef TDM_DEMUX_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'd0;
      end else if (err_nxt && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the team's word-interleaved TDM link, where a transmitter mux sends one channel word per valid cycle. The block locks onto a start-of-frame marker, distributes each incoming word to its channel slot, and presents a complete frame of N_CH words atomically on a parallel output bus. It sits between the serial TDM link and the per-channel consumers and flags framing errors.

## Interface
- N_CH, default 4: channels per frame, ≥2 (not required to be a power of two).
- W, default 8: bits per channel word.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_sof carry a word this cycle.
- in_sof  input  1  word is slot 0 of a frame; ignored when in_valid=0.
- in_data  input  W  channel word.
- out_valid  output  1  one-cycle pulse: out_data holds a new complete frame.
- out_data  output  N_CH*W  frame; channel k at bits [k*W +: W].
- out_err  output  1  one-cycle pulse on a framing error.
- locked  output  1  1 while in COLLECT state.

## Operation
- **States:** HUNT, then COLLECT. Slot counter `slot` has width $clog2(N_CH) and range 0..N_CH-1.
- **Collect buffer:** each slot is written in a collect buffer. A separate output register feeds out_data, so out_data changes only when a frame completes.
- **HUNT:**
  - Words without in_sof are discarded silently, with no error.
  - A valid word with in_sof is stored in slot 0. Then slot=1 and the state goes to COLLECT.
- **COLLECT, valid word without sof:**
  - If slot≠0: the word is stored in `slot` and slot increments.
  - If slot=0: the expected sof is missing. out_err pulses, the word is discarded and the state goes to HUNT.
- **COLLECT, valid word with sof:**
  - If slot=0: the word is stored in slot 0 and slot=1.
  - If slot≠0: this is an early sof. out_err pulses, the partial frame is abandoned, the word is stored in slot 0 and slot=1. The state stays in COLLECT (resync without going through HUNT).
- **Frame completion:**
  - When slot N_CH-1 is stored, the full buffer (including this word) is copied to out_data and out_valid pulses.
  - slot wraps to 0 and the state stays COLLECT.
- **Back-to-back frames:** supported with no idle cycles. The in_valid=0 cycles between words are allowed anywhere and hold all state.
- **No backpressure:** out_valid is not acknowledged. Consumers must sample it in the pulse cycle.
- **Simultaneous events:** in_sof with in_valid=0 is ignored. out_err and out_valid never assert in the same cycle.

## Timing
- **Reset values:**
  - out_valid=0, out_err=0, locked=0, out_data=0.
  - State HUNT, slot=0, collect buffer=0.
- **Frame latency:** out_valid and the updated out_data are registered. They appear 1 cycle after the edge that accepts the last word (slot N_CH-1).
- **Error latency:** out_err is registered and asserts 1 cycle after the offending word's edge.
- **Lock latency:** locked rises 1 cycle after the first accepted sof word. It falls 1 cycle after a missing-sof error.
- **Reset mid-frame:** rst_n low clears everything immediately (asynchronously). No out_valid is produced for the partial frame. After release, the block must see a new sof.
- **Throughput:** one word per cycle; one frame every N_CH valid cycles.

## Configuration
- **Macro:** TDM_DEMUX_ERR_CNT_EN.
- **Defined:**
  - Adds output err_cnt [7:0], reset to 0.
  - It increments in the same cycle out_err asserts and saturates at 255.
  - It clears only on reset.
- **Undefined:** the port and counter do not exist. All other behaviour is identical.

## Test plan
- **Basic frame:** N_CH=4, W=8, words 0x11(sof),0x22,0x33,0x44 on consecutive cycles → out_valid pulse 1 cycle after 0x44; out_data=0x44332211; out_err never asserts.
- **Gapped and back-to-back:**
  - in_valid=0 gaps inserted between words → same out_data, with out_valid delayed by the gap count.
  - A second frame 0xA0(sof)..0xA3 immediately after → second pulse exactly 4 valid cycles later.
- **Hunt:** 0x55,0x66 without sof after reset → no out_valid, no out_err, locked=0. Then a normal frame → locked=1 and correct output.
- **Early sof:** 0x01(sof),0x02 then 0x10(sof),0x20,0x30,0x40 → out_err pulse 1 cycle after 0x10; out_data=0x40302010; out_data unchanged before that pulse.
- **Missing sof:**
  - After a complete frame, 0x99 without sof → out_err pulse, then locked=0.
  - Following non-sof words are ignored.
  - With TDM_DEMUX_ERR_CNT_EN, err_cnt=1; after 300 forced errors, err_cnt=255.
- **Reset mid-frame:** assert rst_n=0 after slot 2 → all outputs 0 immediately. After release, words 0x03,0x04 without sof → no output.
